// File: rtl/flit_buffer_pkg.sv
// Shared helpers for the flit buffer slice: width math used by the arbiter and by
// parents that size select buses from a requester count.
package flit_buffer_pkg;

  // Smallest w with 2**w >= value; 0 for value <= 1.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched cyclically upward from a
// registered priority pointer; the winner becomes lowest priority on the next edge.
module arbiter
  import flit_buffer_pkg::*;
#(
  parameter int unsigned ARBITER_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ARBITER_WIDTH-1:0] request,
  output logic [ARBITER_WIDTH-1:0] grant,
  output logic                     any_grant
);

  localparam int unsigned PtrW = (ARBITER_WIDTH > 1) ? log2_ceil(ARBITER_WIDTH) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] idx;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < ARBITER_WIDTH; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % ARBITER_WIDTH);
      if (grant == '0 && request[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  assign any_grant = |grant;

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = PtrW'((32'(win_idx) + 32'd1) % ARBITER_WIDTH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bin_to_one_hot.sv
// Binary to one-hot decoder for the chip connection select.
module bin_to_one_hot #(
  parameter int unsigned BIN_WIDTH = 1
) (
  input  logic [BIN_WIDTH-1:0]      bin_code,
  output logic [(2**BIN_WIDTH)-1:0] one_hot_code
);

  always_comb begin
    one_hot_code           = '0;
    one_hot_code[bin_code] = 1'b1;
  end

endmodule

// File: rtl/flit_buffer.sv
// Synchronous flit FIFO with registered pop data. A push into a full buffer is accepted
// only when a pop frees a slot on the same edge.
module flit_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  buffer_not_empty
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  full, empty, push, pop;

  // count never exceeds Depth, so its MSB alone marks full.
  assign full  = count_q[ADDR_WIDTH];
  assign empty = (count_q == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      out_d    = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  assign out              = out_q;
  assign buffer_not_empty = !empty;

endmodule

// File: tb/tb_flit_buffer.sv
// Bench for flit_buffer plus its arbiter and decoder companions; FIFO behaviour is
// tracked with a queue model, the companions with directed expectations.
module tb_flit_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] dout;
  logic        bne;
  logic [1:0]  req = '0;
  logic [1:0]  grant;
  logic        any_grant;
  logic [1:0]  bin = '0;
  logic [3:0]  oh;

  always #5 clk = ~clk;

  flit_buffer #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in               (din),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .out              (dout),
    .buffer_not_empty (bne)
  );

  arbiter #(.ARBITER_WIDTH(2)) u_arb (
    .clk       (clk),
    .reset     (~rst_n),
    .request   (req),
    .grant     (grant),
    .any_grant (any_grant)
  );

  bin_to_one_hot #(.BIN_WIDTH(2)) u_dec (
    .bin_code     (bin),
    .one_hot_code (oh)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] model_q[$];
  logic [63:0] exp_out = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of FIFO stimulus; the model applies the pop/push rules at the edge.
  task automatic step(input logic w, input logic r, input logic [63:0] d, input string tag);
    bit pop_ok, push_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    pop_ok  = r && (model_q.size() > 0);
    push_ok = w && ((model_q.size() < 16) || pop_ok);
    if (pop_ok) exp_out = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
    #1;
    chk({tag, "_out"}, dout, exp_out);
    chk({tag, "_not_empty"}, {63'd0, bne}, {63'd0, model_q.size() != 0});
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out", dout, 64'd0);
    chk("rst_not_empty", {63'd0, bne}, 64'd0);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arbiter: pointer starts at 0
    req = 2'b10;
    #1;
    chk("arb_req10_grant", {62'd0, grant}, 64'd2);
    chk("arb_req10_any", {63'd0, any_grant}, 64'd1);
    @(posedge clk);
    #1;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_rr_grant", {62'd0, grant}, (i % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1;
    end
    req = 2'b01;
    #1;
    chk("arb_req01_grant", {62'd0, grant}, 64'd1);
    @(posedge clk);
    #1;
    req = 2'b00;
    #1;
    chk("arb_idle_grant", {62'd0, grant}, 64'd0);
    chk("arb_idle_any", {63'd0, any_grant}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    req = 2'b11;
    #1;
    chk("arb_held_grant", {62'd0, grant}, 64'd2);
    req = 2'b00;

    // Decoder sweep
    for (int i = 0; i < 4; i++) begin
      logic [3:0] one;
      one = 4'b0001;
      bin = 2'(i);
      #1;
      chk("dec_code", {60'd0, oh}, {60'd0, one << i});
      chk("dec_onehot", 64'($countones(oh)), 64'd1);
    end
    @(posedge clk);
    #1;

    // Order and latency
    step(1'b1, 1'b0, 64'h11, "ord_push");
    step(1'b1, 1'b0, 64'h22, "ord_push");
    step(1'b1, 1'b0, 64'h33, "ord_push");
    step(1'b0, 1'b1, 64'h0, "ord_pop");
    chk("ord_first", dout, 64'h11);
    step(1'b0, 1'b1, 64'h0, "ord_pop");
    step(1'b0, 1'b1, 64'h0, "ord_pop");
    chk("ord_last", dout, 64'h33);
    chk("ord_drained", {63'd0, bne}, 64'd0);
    step(1'b0, 1'b1, 64'h0, "empty_pop");

    // Asynchronous reset mid-operation
    step(1'b1, 1'b0, 64'hA1, "mr_push");
    step(1'b1, 1'b0, 64'hA2, "mr_push");
    step(1'b1, 1'b0, 64'hA3, "mr_push");
    step(1'b0, 1'b1, 64'h0, "mr_pop");
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out", dout, 64'd0);
    chk("mr_not_empty", {63'd0, bne}, 64'd0);
    model_q.delete();
    exp_out = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 64'h0, "mr_after_pop");

    // Full, overflow drop, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 64'(i), "full_push");
    step(1'b1, 1'b0, 64'hFF, "full_drop");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 64'h0, "full_pop");
      chk("full_val", dout, 64'(i));
    end
    chk("full_empty", {63'd0, bne}, 64'd0);

    // Wrap with interleaved push/pop
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 64'(32'h1000 + i), "wrap_push");
      step(1'b0, 1'b1, 64'h0, "wrap_pop");
      chk("wrap_val", dout, 64'(32'h1000 + i));
    end

    // Simultaneous push and pop at count 1 and 0
    step(1'b1, 1'b0, 64'hB1, "sim1_push");
    step(1'b1, 1'b1, 64'hB2, "sim1_both");
    chk("sim1_out", dout, 64'hB1);
    step(1'b0, 1'b1, 64'h0, "sim1_pop");
    chk("sim1_next", dout, 64'hB2);
    step(1'b1, 1'b1, 64'hC1, "sim0_both");
    chk("sim0_out_held", dout, 64'hB2);
    chk("sim0_not_empty", {63'd0, bne}, 64'd1);
    step(1'b0, 1'b1, 64'h0, "sim0_pop");

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 64'(32'h200 + i), "sfull_push");
    step(1'b1, 1'b1, 64'hAB, "sfull_both");
    step(1'b1, 1'b0, 64'hCD, "sfull_drop");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 64'h0, "sfull_pop");
    chk("sfull_last", dout, 64'hAB);

    // Random traffic, fill-biased then drain-biased
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 40));
      r = ($urandom_range(0, 99) < ((i < 200) ? 40 : 70));
      step(w, r, {$urandom, $urandom}, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_buffer.md
Name: flit_buffer

Overview:
- Synchronous FIFO for NoC flits, used in the chip-to-NoC mux_in and mux_out paths.
- Two small companion modules are delivered in the same file and verified with it:
  - arbiter: round-robin, selects which buffer is read.
  - bin_to_one_hot: decodes the chip connection select.
- The total RTL is 120-400 lines across the three modules.

Parameters:
- flit_buffer DATA_WIDTH, default 64: flit width in bits.
- flit_buffer ADDR_WIDTH, default 4: pointer width; depth is 2**ADDR_WIDTH entries.
- arbiter ARBITER_WIDTH, default 2: number of requesters.
- bin_to_one_hot BIN_WIDTH, default 1: width of the binary input; the output is 2**BIN_WIDTH bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  DATA_WIDTH  write data.
- wr_en  in  1  push request.
- rd_en  in  1  pop request.
- out  out  DATA_WIDTH  registered pop data.
- buffer_not_empty  out  1  high when the FIFO holds at least one flit.
- arbiter ports:
  - clk, in, 1.
  - reset, in, 1: asynchronous active-high reset; the parent drives it with ~rst_n, so the system keeps one asynchronous active-low reset.
  - request, in, ARBITER_WIDTH.
  - grant, out, ARBITER_WIDTH.
  - any_grant, out, 1.
- bin_to_one_hot ports: bin_code in BIN_WIDTH; one_hot_code out 2**BIN_WIDTH.

Behaviour:
- flit_buffer state:
  - Memory of 2**ADDR_WIDTH x DATA_WIDTH.
  - wr_ptr and rd_ptr, ADDR_WIDTH bits each; they wrap naturally modulo depth.
  - Occupancy counter, ADDR_WIDTH+1 bits.
- flit_buffer reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, out=0, buffer_not_empty=0. Memory contents are not reset.
- Push:
  - When wr_en=1 and count < depth: mem[wr_ptr] <= in, wr_ptr increments.
  - A write while full is dropped; the counter and pointers are unchanged.
- Pop:
  - When rd_en=1 and count > 0: out <= mem[rd_ptr], rd_ptr increments.
  - out holds its value between pops.
  - A read while empty is ignored and out is unchanged.
- Latency: a popped flit appears on out in the cycle after the rd_en edge, aligned with a registered valid generated by the parent.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When empty, only the push happens; the flit is readable from the next cycle.
  - When full, the pop happens and the push happens in the same edge (space is freed concurrently).
- buffer_not_empty = (count != 0). It is combinational from the registered count.
- FIFO ordering is strict; no data corruption across pointer wrap.
- Capacity: depth 2**ADDR_WIDTH ≥ the 2**B-1 credits the parent issues.
- arbiter:
  - grant is one-hot or zero, combinational from request and a registered priority pointer.
  - The first asserted request at or after the pointer, searching cyclically upward, wins.
  - any_grant = |grant.
  - On each edge with any_grant=1, the pointer moves to (granted index + 1) mod ARBITER_WIDTH, so the winner becomes lowest priority.
  - With no grant, the pointer holds.
  - On reset the pointer is 0 (index 0 highest).
  - request=0 gives grant=0.
- bin_to_one_hot: purely combinational; one_hot_code[i] = (bin_code == i); exactly one bit is set for every input value.

Decomposition:
- Shared package: integer log2 (ceiling) function, used for sel widths by the parents.
- flit_buffer needs no sub-module.
- arbiter and bin_to_one_hot are standalone leaf modules in the same file; nothing is shared between them.

Test Plan:
- Reset mid-operation: push 3 flits, assert rst_n=0 asynchronously between edges -> buffer_not_empty=0 and out=0 immediately; a subsequent pop reads nothing.
- FIFO order and latency (ADDR_WIDTH=4, DATA_WIDTH=64): push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 -> out = 0x11, 0x22, 0x33 one cycle after each rd_en edge; buffer_not_empty falls after the third pop.
- Full, overflow and wrap:
  - Push 16 flits 0..15, then push 0xFF -> 0xFF is dropped.
  - Pop 16 -> values 0..15.
  - Push 20 and pop 20 interleaved -> order preserved across wrap.
- Simultaneous push and pop:
  - At count=1 -> count stays 1, order correct.
  - At count=0 with rd_en and wr_en -> out unchanged, buffer_not_empty=1 next cycle.
- Arbiter round-robin (WIDTH=2):
  - request=11 for 4 cycles -> grant 01, 10, 01, 10.
  - request=10 after reset -> grant=10, any_grant=1.
  - request=00 -> grant=00, any_grant=0, pointer held.
- bin_to_one_hot: BIN_WIDTH=2, sweep bin_code 0..3 -> one_hot_code 0001, 0010, 0100, 1000.
